// File: rtl/w_stream_pkg.sv
// Shared definitions for the blocks that produce or consume the serial w stream.
// State encoding is common so that related w-stream blocks decode states identically.
package w_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } w_state_e;

  localparam int unsigned GAP_CNT_W = 4;

endpackage : w_stream_pkg

// File: rtl/w_hold_buf.sv
// Single-entry holding register with a full flag.
// A read and a write on the same edge leave it full with the new word.
module w_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             full_o,
  output logic             full_d_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_en_i) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end else if (rd_en_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) full_q <= 1'b0;
    else         full_q <= full_d;
  end

  // NOTE: the payload register has no reset; full_q alone qualifies its contents.
  always_ff @(posedge Clock) begin
    data_q <= data_d;
  end

  assign full_o   = full_q;
  assign full_d_o = full_d;
  assign data_o   = data_q;

endmodule : w_hold_buf

// File: rtl/w_serializer.sv
// Parallel-to-serial front end for the w stream: valid/ready word input, one bit
// per clock out, one-word holding buffer and an optional idle gap between words.
module w_serializer
  import w_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  w_state_e              state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [WIDTH-1:0]      sreg_q, sreg_d;
  logic                  w_q, w_d;
  logic                  w_valid_q, w_valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;

  logic                  hold_full, hold_full_d;
  logic [WIDTH-1:0]      hold_data;
  logic                  hold_rd, hold_wr;
  logic                  accept, bypass, next_word;

  assign accept = in_valid && !hold_full;
  // A word taken straight into the shifter must not also land in the hold buffer.
  assign hold_wr = accept && !bypass;

  w_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .wr_en_i   (hold_wr),
    .wr_data_i (data_in),
    .rd_en_i   (hold_rd),
    .full_o    (hold_full),
    .full_d_o  (hold_full_d),
    .data_o    (hold_data)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    sreg_d    = sreg_q;
    hold_rd   = 1'b0;
    bypass    = 1'b0;
    next_word = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sreg_d  = data_in;
          bypass  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d  = cnt_q + 1'b1;
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        end else if (GAP != 0) begin
          state_d = ST_GAP;
          gcnt_d  = '0;
        end else begin
          next_word = 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) next_word = 1'b1;
        else                    gcnt_d    = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Held word has priority over one arriving on this same edge.
    if (next_word) begin
      cnt_d = '0;
      if (hold_full) begin
        state_d = ST_SHIFT;
        sreg_d  = hold_data;
        hold_rd = 1'b1;
      end else if (accept) begin
        state_d = ST_SHIFT;
        sreg_d  = data_in;
        bypass  = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Outputs are computed from next state so they can be registered without lag.
  always_comb begin
    w_valid_d = (state_d == ST_SHIFT);
    w_d       = w_valid_d && (MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0]);
    last_d    = w_valid_d && (cnt_d == CNT_LAST);
    busy_d    = (state_d != ST_IDLE) || hold_full_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      sreg_q    <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gcnt_q    <= gcnt_d;
      sreg_q    <= sreg_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign in_ready = !hold_full;
  assign w        = w_q;
  assign w_valid  = w_valid_q;
  assign last     = last_q;
  assign busy     = busy_q;

endmodule : w_serializer
